fsic_clock_div_prog: RTL and testbench

Programmable integer clock divider, the parametrised successor of the fixed divide-by-4 divider. Divides `in` by a runtime ratio N (2..2^DIV_W-1). Ratio changes are applied only at period boundaries, so the output is glitch-free. Also provides a glitch-free stop/start enable and a rising-edge strobe in the source domain; used by io_serdes/testbench clocking and future FSIC clock generation.

---
 rtl/fsic_clk_pkg.sv | 19 +
 rtl/fsic_clk_div_core.sv | 69 ++++++
 rtl/fsic_clock_div_prog.sv | 77 +++++++
 tb/tb_fsic_clock_div_prog.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fsic_clk_pkg.sv
// fsic_clk_pkg
// Shared definitions for the programmable clock divider: minimum legal
// ratio, divider state encoding and the ratio clamp helper.
package fsic_clk_pkg;

    localparam int DIV_MIN = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } clk_state_t;

    // Ratios below DIV_MIN cannot produce a high and a low phase, so they
    // are raised to DIV_MIN; all other values pass through untouched.
    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < 32'(DIV_MIN)) ? 32'(DIV_MIN) : v;
    endfunction

endpackage

// File: rtl/fsic_clk_div_core.sv
// fsic_clk_div_core
// Period counter and registered divided-clock generation.
// Ports:
//   in        source clock (posedge)
//   reset     async active-high reset
//   en        run enable, honoured only at period boundaries
//   n_cur     ratio of the period in progress
//   n_next    ratio for the period that starts at the next boundary
//   at_bound  high when the coming edge ends a period (always true in IDLE)
//   out       divided clock
//   out_rise  one-cycle pulse coincident with out going 0->1
//
// state | meaning
// IDLE  | stopped, cnt parked at N-1, out low
// RUN   | counting 0..N-1, out high for the first ceil(N/2) counts
module fsic_clk_div_core
    import fsic_clk_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             in,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] n_cur,
    input  logic [DIV_W-1:0] n_next,
    output logic             at_bound,
    output logic             out,
    output logic             out_rise
);

    clk_state_t       state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W:0]   cnt_inc;
    logic [DIV_W:0]   high_cur;

    // One extra bit so ceil(N/2) cannot overflow at the largest ratio.
    assign cnt_inc  = {1'b0, cnt} + (DIV_W+1)'(1);
    assign high_cur = ({1'b0, n_cur} + (DIV_W+1)'(1)) >> 1;
    assign at_bound = (state == IDLE) || (cnt == n_cur - DIV_W'(1));

    always_ff @(posedge in or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= DIV_W'(DEFAULT_DIV - 1);
            out      <= 1'b0;
            out_rise <= 1'b0;
        end else begin
            out_rise <= 1'b0;
            if (at_bound) begin
                if (en) begin
                    state    <= RUN;
                    cnt      <= '0;
                    out      <= 1'b1;
                    out_rise <= 1'b1;
                end else begin
                    // Parked at N-1 so the first enabled edge is a boundary.
                    state <= IDLE;
                    cnt   <= n_next - DIV_W'(1);
                    out   <= 1'b0;
                end
            end else begin
                cnt <= cnt + DIV_W'(1);
                out <= (cnt_inc < high_cur);
            end
        end
    end

endmodule

// File: rtl/fsic_clock_div_prog.sv
// fsic_clock_div_prog
// Programmable integer clock divider with glitch-free ratio changes and
// stop/start. Ratio updates take effect only at period boundaries.
// Ports:
//   in        source clock (posedge)
//   reset     async active-high reset
//   en        run enable
//   div_val   requested ratio, sampled when div_load=1
//   div_load  one-cycle ratio change request
//   div_ack   one-cycle pulse on the edge a new ratio takes effect
//   cur_div   active ratio (always >= 2)
//   out       divided clock (registered)
//   out_rise  one-cycle pulse with out going 0->1
module fsic_clock_div_prog
    import fsic_clk_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             in,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic [DIV_W-1:0] cur_div,
    output logic             out,
    output logic             out_rise
);

    logic [DIV_W-1:0] ld_val;
    logic [DIV_W-1:0] pending;
    logic             pending_valid;
    logic [DIV_W-1:0] n_next;
    logic             at_bound;
    logic             apply;

    assign ld_val = DIV_W'(clamp_div(32'(div_val)));

    // A load on the boundary edge itself wins over any older pending value.
    assign apply  = at_bound && (div_load || pending_valid);
    assign n_next = !apply   ? cur_div :
                    div_load ? ld_val  : pending;

    always_ff @(posedge in or posedge reset) begin
        if (reset) begin
            cur_div       <= DIV_W'(DEFAULT_DIV);
            pending       <= DIV_W'(DEFAULT_DIV);
            pending_valid <= 1'b0;
            div_ack       <= 1'b0;
        end else begin
            div_ack <= apply;
            if (apply) begin
                cur_div       <= n_next;
                pending_valid <= 1'b0;
            end else if (div_load) begin
                pending       <= ld_val;
                pending_valid <= 1'b1;
            end
        end
    end

    fsic_clk_div_core #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .in       (in),
        .reset    (reset),
        .en       (en),
        .n_cur    (cur_div),
        .n_next   (n_next),
        .at_bound (at_bound),
        .out      (out),
        .out_rise (out_rise)
    );

endmodule

// File: tb/tb_fsic_clock_div_prog.sv
// tb_fsic_clock_div_prog
// Directed bench for fsic_clock_div_prog: expected waveforms are written
// out by hand as bit patterns, first sampled edge in the MSB.
module tb_fsic_clock_div_prog;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       div_ack;
    logic [7:0] cur_div;
    logic       out;
    logic       out_rise;

    int total = 0;
    int bad   = 0;

    logic [31:0] po, pr, pa;

    fsic_clock_div_prog #(
        .DIV_W       (8),
        .DEFAULT_DIV (4)
    ) dut (
        .in       (clk),
        .reset    (reset),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .div_ack  (div_ack),
        .cur_div  (cur_div),
        .out      (out),
        .out_rise (out_rise)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample out/out_rise/div_ack after each of n edges.
    task automatic capture(input int n, output logic [31:0] o,
                           output logic [31:0] r, output logic [31:0] a);
        o = '0; r = '0; a = '0;
        for (int i = 0; i < n; i++) begin
            step();
            o = {o[30:0], out};
            r = {r[30:0], out_rise};
            a = {a[30:0], div_ack};
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; div_load = 1'b0; div_val = 8'd0;
        #2 reset = 1'b1;
        #1;
        chk("rst_out",    32'(out),      32'd0);
        chk("rst_rise",   32'(out_rise), 32'd0);
        chk("rst_ack",    32'(div_ack),  32'd0);
        chk("rst_curdiv", 32'(cur_div),  32'd4);
        chk("rst_cnt",    32'(dut.u_core.cnt), 32'd3);
        step(); step();
        reset = 1'b0;
        step();
        chk("idle_out", 32'(out), 32'd0);
        chk("idle_cnt", 32'(dut.u_core.cnt), 32'd3);

        // Default ratio 4: 2 high / 2 low, first high one edge after en.
        en = 1'b1;
        capture(8, po, pr, pa);
        chk("div4_out",  po, 32'b11001100);
        chk("div4_rise", pr, 32'b10001000);
        chk("div4_ack",  pa, 32'b00000000);
        chk("div4_cur",  32'(cur_div), 32'd4);

        // Load 5 mid-period: applied at the next boundary, 3 high / 2 low.
        step();
        div_load = 1'b1; div_val = 8'd5;
        step();
        div_load = 1'b0;
        chk("ld5_noack", 32'(div_ack), 32'd0);
        chk("ld5_cur0",  32'(cur_div), 32'd4);
        capture(12, po, pr, pa);
        chk("div5_out",  po, 32'b001110011100);
        chk("div5_rise", pr, 32'b001000010000);
        chk("div5_ack",  pa, 32'b001000000000);
        chk("div5_cur",  32'(cur_div), 32'd5);

        // Load 0 then 7 in one period: single ack, last value wins.
        step();
        div_load = 1'b1; div_val = 8'd0;
        step();
        chk("lw_ack_a", 32'(div_ack), 32'd0);
        div_val = 8'd7;
        step();
        chk("lw_ack_b", 32'(div_ack), 32'd0);
        div_load = 1'b0;
        capture(12, po, pr, pa);
        chk("div7_out",  po, 32'b001111000111);
        chk("div7_rise", pr, 32'b001000000100);
        chk("div7_ack",  pa, 32'b001000000000);
        chk("div7_cur",  32'(cur_div), 32'd7);

        // Load 1 clamps to 2: 1/1 toggle.
        div_load = 1'b1; div_val = 8'd1;
        step();
        div_load = 1'b0;
        chk("ld1_out", 32'(out), 32'd1);
        capture(7, po, pr, pa);
        chk("div2_out", po, 32'b0001010);
        chk("div2_ack", pa, 32'b0001000);
        chk("div2_cur", 32'(cur_div), 32'd2);

        // Load 6 exactly on a boundary (N=2): bypasses pending.
        div_load = 1'b1; div_val = 8'd6;
        step();
        div_load = 1'b0;
        chk("ld6_ack",  32'(div_ack),  32'd1);
        chk("ld6_cur",  32'(cur_div),  32'd6);
        chk("ld6_rise", 32'(out_rise), 32'd1);

        // Drop en in the high phase: period completes, then out parks low.
        step();
        en = 1'b0;
        capture(8, po, pr, pa);
        chk("stop_out",  po, 32'b10000000);
        chk("stop_rise", pr, 32'b00000000);
        chk("stop_cnt",  32'(dut.u_core.cnt), 32'd5);
        en = 1'b1;
        capture(6, po, pr, pa);
        chk("start_out",  po, 32'b111000);
        chk("start_rise", pr, 32'b100000);

        // Back to 4 on a boundary, then collide a load of 3 with the wrap.
        div_load = 1'b1; div_val = 8'd4;
        step();
        div_load = 1'b0;
        chk("ld4_ack", 32'(div_ack), 32'd1);
        chk("ld4_cur", 32'(cur_div), 32'd4);
        step(); step(); step();
        chk("pre_coll_out", 32'(out), 32'd0);
        div_load = 1'b1; div_val = 8'd3;
        step();
        div_load = 1'b0;
        chk("coll_ack",  32'(div_ack),  32'd1);
        chk("coll_rise", 32'(out_rise), 32'd1);
        chk("coll_cur",  32'(cur_div),  32'd3);
        capture(5, po, pr, pa);
        chk("div3_out",  po, 32'b10110);
        chk("div3_rise", pr, 32'b00100);
        chk("div3_ack",  pa, 32'b00000);

        // Async reset mid-high with a load pending.
        step();
        div_load = 1'b1; div_val = 8'd9;
        step();
        div_load = 1'b0;
        chk("pre_rst_out", 32'(out), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_out",  32'(out),      32'd0);
        chk("arst_rise", 32'(out_rise), 32'd0);
        chk("arst_ack",  32'(div_ack),  32'd0);
        chk("arst_cur",  32'(cur_div),  32'd4);
        en = 1'b0;
        step(); step();
        reset = 1'b0;
        capture(6, po, pr, pa);
        chk("post_rst_out", po, 32'b000000);
        chk("post_rst_ack", pa, 32'b000000);
        chk("post_rst_cur", 32'(cur_div), 32'd4);
        en = 1'b1;
        capture(4, po, pr, pa);
        chk("post_rst_run_out",  po, 32'b1100);
        chk("post_rst_run_rise", pr, 32'b1000);
        chk("post_rst_run_ack",  pa, 32'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
